reg_wb_ctrl: RTL

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

---
 rtl/reg_wb_ctrl_pkg.sv | 15 +
 rtl/reg_wb_ctrl_wb_fifo.sv | 79 +++++++
 rtl/reg_wb_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/reg_wb_ctrl_pkg.sv
// Shared CPU constants for the write-back path.
//   XLEN          - register data width
//   REG_ADDR_W    - register-file address width
//   WB_FIFO_DEPTH - number of buffered long-latency results
//   NUM_REGS      - number of architectural registers
package reg_wb_ctrl_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int NUM_REGS      = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// wb_fifo: small in-order buffer for long-latency write-back results.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   push, push_addr/data  - enqueue request (ignored when full)
//   pop                   - dequeue request (ignored when empty)
//   full, empty           - status, derived from the registered count only
//   head_addr, head_data  - oldest entry, valid while empty is low
// A pushed entry only becomes visible through empty/head after the edge
// that stores it, so there is no same-edge bypass to the consumer.
module wb_fifo
  import reg_wb_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = WB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [REG_ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0]     head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [REG_ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0]     data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths keep order.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign head_addr = addr_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  // Storage needs no reset: count gates visibility of every slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
        addr_mem[gi] <= push_addr;
        data_mem[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: register-file write-back arbiter and long-latency scoreboard.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   alu_valid/addr/data              - single-cycle result, cannot stall
//   div_valid/addr/data, div_ready   - long-latency result handshake
//   issue_valid/long/addr            - ID-stage issue, marks pending writes
//   chk_addr1/2, busy1/2             - combinational pending-write queries
//   write_enable/addr/data           - registered register-file write port
// The ALU always wins the write port; buffered long-latency results drain
// only in cycles with no ALU result.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
#(
  parameter int XLEN       = reg_wb_ctrl_pkg::XLEN,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  div_valid,
  input  logic [REG_ADDR_W-1:0] div_addr,
  input  logic [XLEN-1:0]       div_data,
  output logic                  div_ready,
  input  logic                  issue_valid,
  input  logic                  issue_long,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_data
);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [XLEN-1:0]       head_data;

  logic [NUM_REGS-1:0] scoreboard_reg;
  logic [NUM_REGS-1:0] sb_set;
  logic [NUM_REGS-1:0] sb_clr;

  // Pop only in ALU-free cycles; the popped entry is written this edge.
  assign fifo_pop  = ~alu_valid & ~fifo_empty;
  assign div_ready = ~fifo_full;

  wb_fifo #(
    .DATA_W (XLEN),
    .DEPTH  (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (div_valid),
    .push_addr (div_addr),
    .push_data (div_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  // Writes to x0 still consume their slot/entry but never strobe the
  // register file. Idle cycles keep the last address/data on the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else if (alu_valid) begin
      write_enable <= (alu_addr != '0);
      write_addr   <= alu_addr;
      write_data   <= alu_data;
    end else if (!fifo_empty) begin
      write_enable <= (head_addr != '0);
      write_addr   <= head_addr;
      write_data   <= head_data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  // Bit 0 never sets. A new issue to a register wins over a pop that
  // retires the previous pending write to the same register.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    assign sb_set[gi] = (gi != 0) && issue_valid && issue_long &&
                        (issue_addr == REG_ADDR_W'(gi));
    assign sb_clr[gi] = fifo_pop && (head_addr == REG_ADDR_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scoreboard_reg <= '0;
    end else begin
      scoreboard_reg <= (scoreboard_reg & ~sb_clr) | sb_set;
    end
  end

  assign busy1 = (chk_addr1 != '0) && scoreboard_reg[chk_addr1];
  assign busy2 = (chk_addr2 != '0) && scoreboard_reg[chk_addr2];

endmodule
